// File: rtl/cart_mbc1.sv
// MBC1 cartridge mapper: bank registers, address translation and a single-outstanding
// backing-store handshake. Define CART_RAM_EN to build in external cartridge RAM.
module cart_mbc1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        wr,
  input  logic        rd,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  localparam int unsigned AW   = 22;
  localparam int unsigned DW   = 8;
  localparam int unsigned BW   = 5;
  localparam int unsigned UW   = 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            rd_prev_q, wr_prev_q;
  logic [DW-1:0]   dout_q, dout_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_req_q, mem_req_d;
  logic            busy_q, busy_d;
  logic [BW-1:0]   rom_bank_q, rom_bank_d;
  logic [UW-1:0]   upper_q, upper_d;
  logic            mode_q, mode_d;
`ifdef CART_RAM_EN
  logic            ram_en_q, ram_en_d;
`endif
  logic            rd_rise, wr_rise;

  // Next-state, register-file and address-translation logic
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_req_d   = mem_req_q;
    rom_bank_d  = rom_bank_q;
    upper_d     = upper_q;
    mode_d      = mode_q;
`ifdef CART_RAM_EN
    ram_en_d    = ram_en_q;
`endif
    rd_rise     = rd & ~rd_prev_q;
    wr_rise     = wr & ~wr_prev_q;

    unique case (state_q)
      S_IDLE: begin
        // A simultaneous read edge is dropped when a write edge is present
        if (wr_rise) begin
          case (a[15:13])
`ifdef CART_RAM_EN
            3'b000: ram_en_d = (din[3:0] == 4'hA);
`endif
            3'b001: rom_bank_d = (din[4:0] == 5'd0) ? 5'd1 : din[4:0];
            3'b010: upper_d    = din[1:0];
            3'b011: mode_d     = din[0];
`ifdef CART_RAM_EN
            3'b101: begin
              if (ram_en_q) begin
                state_d     = S_REQ;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = din;
                mem_addr_d  = {1'b1, 6'b0, (mode_q ? upper_q : 2'b00), a[12:0]};
              end
            end
`endif
            default: ;
          endcase
        end else if (rd_rise) begin
          case (a[15:13])
            3'b000, 3'b001: begin
              state_d     = S_REQ;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              mem_wdata_d = din;
              mem_addr_d  = {1'b0, (mode_q ? {upper_q, 5'b0} : 7'd0), a[13:0]};
            end
            3'b010, 3'b011: begin
              state_d     = S_REQ;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              mem_wdata_d = din;
              mem_addr_d  = {1'b0, upper_q, rom_bank_q, a[13:0]};
            end
            3'b101: begin
`ifdef CART_RAM_EN
              if (ram_en_q) begin
                state_d     = S_REQ;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b0;
                mem_wdata_d = din;
                mem_addr_d  = {1'b1, 6'b0, (mode_q ? upper_q : 2'b00), a[12:0]};
              end else begin
                dout_d = 8'hFF;
              end
`else
              dout_d = 8'hFF;
`endif
            end
            default: ;
          endcase
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            dout_d = mem_rdata;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_prev_q   <= 1'b0;
      wr_prev_q   <= 1'b0;
      dout_q      <= 8'hFF;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      rom_bank_q  <= 5'd1;
      upper_q     <= '0;
      mode_q      <= 1'b0;
`ifdef CART_RAM_EN
      ram_en_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_prev_q   <= rd;
      wr_prev_q   <= wr;
      dout_q      <= dout_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      rom_bank_q  <= rom_bank_d;
      upper_q     <= upper_d;
      mode_q      <= mode_d;
`ifdef CART_RAM_EN
      ram_en_q    <= ram_en_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_req   = mem_req_q;
  assign busy      = busy_q;

endmodule

// File: doc/cart_mbc1.md
CART_MBC1 -- requirements
Module: cart_mbc1

Interface
REQ-001 SHALL have port clk, input, 1, core clock (4.19 MHz domain).
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port a, input, 16, cartridge address bus from core.
REQ-004 SHALL have port din, input, 8, write data from core.
REQ-005 SHALL have port dout, output, 8, read data to core.
REQ-006 SHALL have port wr, input, 1, core write enable, level.
REQ-007 SHALL have port rd, input, 1, core read enable, level.
REQ-008 SHALL have port mem_addr, output, 22, backing-store byte address; bit 21 = 1 selects RAM.
REQ-009 SHALL have ports mem_wdata (output, 8), mem_we (output, 1), mem_req (output, 1), mem_ack (input, 1) and mem_rdata (input, 8): backing-store request/response.
REQ-010 SHALL have port busy, output, 1, high while an access is outstanding.

Function
REQ-011 SHALL detect an access on a rising edge of rd or wr (high now, low previous cycle); wr SHALL win if both rise together, and the read SHALL be discarded.
REQ-012 SHALL run FSM IDLE -> REQ -> DONE -> IDLE; IDLE leaves only on a detected access that needs backing store.
REQ-013 SHALL, in REQ, hold mem_req=1 with constant mem_addr/mem_we/mem_wdata until the cycle mem_ack=1, then go to DONE.
REQ-014 SHALL, on a read ack, latch mem_rdata into dout in that same cycle; dout SHALL hold its value until the next completed read.
REQ-015 SHALL spend exactly one cycle in DONE with mem_req=0; minimum access latency is 3 cycles from the edge to a return to IDLE.
REQ-016 SHALL ignore any rd/wr edges outside IDLE; edge history SHALL keep updating.
REQ-017 SHALL, on a write to 0x0000-0x1FFF, set ram_en=1 if din[3:0]==4'hA and ram_en=0 otherwise, with no mem_req.
REQ-018 SHALL, on a write to 0x2000-0x3FFF, set rom_bank=din[4:0], forcing 5'd1 when din[4:0]==0, with no mem_req.
REQ-019 SHALL, on a write to 0x4000-0x5FFF, set upper=din[1:0], with no mem_req.
REQ-020 SHALL, on a write to 0x6000-0x7FFF, set mode=din[0], with no mem_req.
REQ-021 SHALL map reads of 0x0000-0x3FFF to mem_addr = {1'b0, (mode ? {upper,5'b0} : 7'd0), a[13:0]}.
REQ-022 SHALL map reads of 0x4000-0x7FFF to mem_addr = {1'b0, upper, rom_bank, a[13:0]}.
REQ-023 SHALL map read or write to 0xA000-0xBFFF with ram_en=1 to mem_addr = {1'b1, 6'b0, (mode ? upper : 2'b00), a[12:0]}, with mem_we=wr-edge and mem_wdata=din.
REQ-024 SHALL make a read of 0xA000-0xBFFF with ram_en=0 set dout=8'hFF in the cycle after the edge, without mem_req; a write there SHALL be dropped.
REQ-025 SHALL ignore all accesses to 0x8000-0x9FFF and 0xC000-0xFFFF (no mem_req, dout unchanged).
REQ-026 SHALL drive busy=1 in REQ and DONE, else 0.

Reset
REQ-027 SHALL set, on rst=1 at a clk edge: FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dout=8'hFF, busy=0, ram_en=0, rom_bank=1, upper=0, mode=0, edge history=0.
REQ-028 SHALL, on rst mid-access, drop mem_req in the next cycle and ignore a late mem_ack.

Configuration
REQ-029 SHALL implement external cartridge RAM (REQ-017, REQ-023, REQ-024) only when macro CART_RAM_EN is defined.
REQ-030 SHALL, without CART_RAM_EN, return 8'hFF for every read of 0xA000-0xBFFF with no mem_req, drop writes there, keep ram_en out of the logic, and leave mem_addr[21] constant 0.

Verification
REQ-031 SHALL check: after reset, rd rises at a=0x4123, ack after 2 cycles with rdata=0x5A -> mem_addr=0x004123, dout=0x5A.
REQ-032 SHALL check: write 0x00 to 0x2000, then read 0x4000 -> mem_addr=0x004000 (bank forced to 1).
REQ-033 SHALL check: write 0x1F to 0x2000, 0x03 to 0x4000 and 0x01 to 0x6000, then read 0x0010 -> mem_addr=0x180010; read 0x7FFF -> mem_addr=0x1FFFFF.
REQ-034 SHALL check: read 0xA000 with RAM disabled -> dout=0xFF, no mem_req; write 0x0A to 0x0000, write 0x77 to 0xA005 -> mem_req with mem_we=1, mem_addr=0x200005, mem_wdata=0x77.
REQ-035 SHALL check: rd and wr rise together at 0xA001 with RAM enabled -> write only; a second rd edge while busy -> no second request.
REQ-036 SHALL check: rst asserted in REQ -> mem_req=0 next cycle, dout=0xFF, rom_bank=1.
